// File: rtl/tx_frame_ser.sv
// tx_frame_ser: transmit framing serializer sitting after tx_crc.
// A load strobe captures a payload word and its CRC; the block then emits
// SYNC_WORD, the payload and the CRC as one MSB-first bit stream.
//
// Optional build macro SER_PARITY_EN: appends one even-parity bit computed
// over payload+CRC (sync excluded) after the last CRC bit.
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   ser_load     one-cycle load strobe (accepted in IDLE or DONE)
//   ser_data_i   payload, sampled on an accepted load
//   ser_crc_i    CRC, sampled on an accepted load
//   ser_bit_o    serial bit
//   ser_bit_vld  ser_bit_o holds a frame bit this cycle
//   ser_busy     frame in progress, loads are dropped
//   ser_done     one-cycle pulse after the last frame bit
//   ser_ovf      one-cycle pulse, a load was dropped on the previous edge
//   ser_cnt      bit index within the current phase
module tx_frame_ser #(
  parameter int                     DATA_LENGTH = 32,
  parameter int                     CRC_LENGTH  = 8,
  parameter int                     SYNC_LENGTH = 8,
  parameter logic [SYNC_LENGTH-1:0] SYNC_WORD   = 8'hA5
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         ser_load,
  input  logic [DATA_LENGTH-1:0]                       ser_data_i,
  input  logic [CRC_LENGTH-1:0]                        ser_crc_i,
  output logic                                         ser_bit_o,
  output logic                                         ser_bit_vld,
  output logic                                         ser_busy,
  output logic                                         ser_done,
  output logic                                         ser_ovf,
  output logic [$clog2(DATA_LENGTH+CRC_LENGTH+1)-1:0]  ser_cnt
);

  localparam int SR_W = DATA_LENGTH + CRC_LENGTH;
  localparam int CW   = $clog2(SR_W + 1);
  localparam logic [CW-1:0] SYNC_LAST  = CW'(SYNC_LENGTH - 1);
  localparam logic [CW-1:0] FRAME_LAST = CW'(SR_W - 1);

`ifdef SER_PARITY_EN
  typedef enum logic [2:0] {IDLE, SYNC, FRAME, PARITY, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, SYNC, FRAME, DONE} state_t;
`endif

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SR_W-1:0]        sreg_q;
  logic [SYNC_LENGTH-1:0] sync_q;
  logic                   ovf_q;
  logic                   load_ok;
  logic                   busy_st;
`ifdef SER_PARITY_EN
  logic                   par_q;
`endif

  // DONE accepts loads like IDLE so frames can run with a single gap cycle.
  assign load_ok = ser_load && (state_q == IDLE || state_q == DONE);
  assign busy_st = (state_q == SYNC) || (state_q == FRAME)
`ifdef SER_PARITY_EN
                   || (state_q == PARITY)
`endif
                   ;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ser_bit_o   = 1'b0;
    ser_bit_vld = 1'b0;
    ser_busy    = 1'b0;
    ser_done    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        ser_done = (state_q == DONE);
        cnt_d    = '0;
        state_d  = load_ok ? SYNC : IDLE;
      end
      SYNC: begin
        ser_bit_o   = sync_q[SYNC_LENGTH-1];
        ser_bit_vld = 1'b1;
        ser_busy    = 1'b1;
        if (cnt_q == SYNC_LAST) begin
          state_d = FRAME;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FRAME: begin
        ser_bit_o   = sreg_q[SR_W-1];
        ser_bit_vld = 1'b1;
        ser_busy    = 1'b1;
        if (cnt_q == FRAME_LAST) begin
`ifdef SER_PARITY_EN
          state_d = PARITY;
`else
          state_d = DONE;
`endif
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef SER_PARITY_EN
      PARITY: begin
        ser_bit_o   = par_q;
        ser_bit_vld = 1'b1;
        ser_busy    = 1'b1;
        state_d     = DONE;
        cnt_d       = '0;
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Datapath: sync and payload shift registers, overflow flag.
  // The sync word is shifted rather than indexed by cnt so the output bit
  // is always a flop MSB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sreg_q <= '0;
      sync_q <= '0;
      ovf_q  <= 1'b0;
`ifdef SER_PARITY_EN
      par_q  <= 1'b0;
`endif
    end else begin
      ovf_q <= ser_load && busy_st;
      if (load_ok) begin
        sreg_q <= {ser_data_i, ser_crc_i};
        sync_q <= SYNC_WORD;
`ifdef SER_PARITY_EN
        par_q  <= ^{ser_data_i, ser_crc_i};
`endif
      end else if (state_q == SYNC) begin
        sync_q <= sync_q << 1;
      end else if (state_q == FRAME) begin
        sreg_q <= sreg_q << 1;
      end
    end
  end

  assign ser_ovf = ovf_q;
  assign ser_cnt = cnt_q;

endmodule

// File: tb/tb_tx_frame_ser.sv
// Directed bench for tx_frame_ser: table of frames with hand-computed
// bit streams, plus reset/idle and reset-mid-frame sequences.
module tb_tx_frame_ser;

`ifdef SER_PARITY_EN
  localparam int FL = 49;
`else
  localparam int FL = 48;
`endif

  logic        clk;
  logic        rst_n;
  logic        ser_load;
  logic [31:0] ser_data_i;
  logic [7:0]  ser_crc_i;
  logic        ser_bit_o, ser_bit_vld, ser_busy, ser_done, ser_ovf;
  logic [5:0]  ser_cnt;

  int checks = 0;
  int errors = 0;

  tx_frame_ser dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ser_load    (ser_load),
    .ser_data_i  (ser_data_i),
    .ser_crc_i   (ser_crc_i),
    .ser_bit_o   (ser_bit_o),
    .ser_bit_vld (ser_bit_vld),
    .ser_busy    (ser_busy),
    .ser_done    (ser_done),
    .ser_ovf     (ser_ovf),
    .ser_cnt     (ser_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] d;
    logic [7:0]  c;
    logic [47:0] stream;  // sync, payload, CRC in transmit order
    logic        par;     // even parity over payload+CRC
    int          ovf_at;  // frame cycle carrying a second load, -1 none
    bit          b2b;     // load in the previous frame's done cycle
  } vec_t;

  vec_t vecs [6];

  // {vld, busy, done, ovf, bit, cnt}
  function automatic logic [10:0] obs();
    return {ser_bit_vld, ser_busy, ser_done, ser_ovf, ser_bit_o, ser_cnt};
  endfunction

  task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b (vld busy done ovf bit cnt)", name, act, exp);
    end
  endtask

  // Starts at a negedge in IDLE/DONE, ends at the negedge of the DONE cycle.
  task automatic send_frame(input int id, input logic [31:0] d, input logic [7:0] c,
                            input logic [FL-1:0] exp, input int ovf_at);
    logic       e_ovf;
    logic [5:0] e_cnt;
    ser_load   = 1'b1;
    ser_data_i = d;
    ser_crc_i  = c;
    @(negedge clk);
    ser_load   = 1'b0;
    ser_data_i = ~d;
    ser_crc_i  = ~c;
    for (int i = 0; i < FL; i++) begin
      e_ovf = (ovf_at >= 0) && (i == ovf_at + 1);
      e_cnt = (i < 8) ? 6'(i) : (i < 48) ? 6'(i - 8) : 6'd0;
      chk($sformatf("frame%0d_bit%0d", id, i), obs(), {1'b1, 1'b1, 1'b0, e_ovf, exp[FL-1-i], e_cnt});
      if (i == ovf_at) begin
        ser_load   = 1'b1;
        ser_data_i = 32'hFFFF_FFFF;
      end else begin
        ser_load   = 1'b0;
      end
      @(negedge clk);
    end
    chk($sformatf("frame%0d_done", id), obs(), 11'b00100_000000);
  endtask

  initial begin
    logic [FL-1:0] e;
    vecs[0] = '{32'h1234_5678, 8'h5A, 48'hA5_12345678_5A, 1'b1, -1, 1'b0};
    vecs[1] = '{32'hDEAD_BEEF, 8'h3C, 48'hA5_DEADBEEF_3C, 1'b0, 10, 1'b0};
    vecs[2] = '{32'h0000_0001, 8'h01, 48'hA5_00000001_01, 1'b0, -1, 1'b0};
    vecs[3] = '{32'h0000_0001, 8'h01, 48'hA5_00000001_01, 1'b0, -1, 1'b1};
    vecs[4] = '{32'h0000_0007, 8'h01, 48'hA5_00000007_01, 1'b0, -1, 1'b0};
    vecs[5] = '{32'h8000_0000, 8'h00, 48'hA5_80000000_00, 1'b1, -1, 1'b1};

    rst_n      = 1'b0;
    ser_load   = 1'b0;
    ser_data_i = '0;
    ser_crc_i  = '0;

    // reset held 5 cycles, then 20 idle cycles
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("reset%0d", i), obs(), '0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("idle%0d", i), obs(), '0);
    end

    for (int v = 0; v < 6; v++) begin
      if (!vecs[v].b2b) begin
        @(negedge clk);
        chk($sformatf("gap_before%0d", v), obs(), '0);
      end
`ifdef SER_PARITY_EN
      e = {vecs[v].stream, vecs[v].par};
`else
      e = vecs[v].stream;
`endif
      send_frame(v, vecs[v].d, vecs[v].c, e, vecs[v].ovf_at);
    end
    // after the overflow frame the gap check above also proves no extra frame
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("idle_after%0d", i), obs(), '0);
    end

    // reset mid-frame at FRAME cnt=20
    ser_load   = 1'b1;
    ser_data_i = 32'hCAFE_F00D;
    ser_crc_i  = 8'h77;
    @(negedge clk);
    ser_load = 1'b0;
    for (int i = 0; i < 28; i++) @(negedge clk);
    chk("midframe_cnt20", {obs()} & 11'b11110_111111, 11'b11000_010100);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midframe_reset", obs(), '0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("post_reset%0d", i), obs(), '0);
    end
`ifdef SER_PARITY_EN
    e = {vecs[0].stream, vecs[0].par};
`else
    e = vecs[0].stream;
`endif
    send_frame(6, vecs[0].d, vecs[0].c, e, -1);
    @(negedge clk);
    chk("final_idle", obs(), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
